// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel readout sequencer.
//   pixel_state_e : sequencer phase encoding
//   DEF_*         : default parameter values for pixel_seq_ctrl
//   max_int       : elaboration-time helper for sizing counters
package pixel_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ERASE   = 3'd1,
    S_EXPOSE  = 3'd2,
    S_CONVERT = 3'd3,
    S_READ    = 3'd4
  } pixel_state_e;

  localparam int DEF_ROWS         = 2;
  localparam int DEF_ADC_BITS     = 8;
  localparam int DEF_ERASE_CYCLES = 5;
  localparam int DEF_EXP_W        = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pixel_cycle_counter.sv
// Loadable down-counter used to time every fixed-length phase.
//   clk, reset : clock, async active-high reset
//   load       : load load_val this clock (takes priority over counting)
//   load_val   : phase length in clocks (>= 1)
//   done       : high during the last clock of the loaded duration
// After loading N, done is high on the N-th clock; the count then parks at 0.
module pixel_cycle_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count == W'(1));

endmodule

// File: rtl/pixel_seq_ctrl.sv
// Pixel array frame sequencer: erase -> expose -> ADC ramp -> row readout.
//   clk, reset     : clock, async active-high reset
//   start          : request one frame (accepted in IDLE only)
//   continuous     : restart a new frame directly at frame end
//   abort          : synchronous return to IDLE, all outputs cleared
//   expose_cycles  : exposure length, latched when a frame starts (0 -> 1)
//   erase/expose/convert/read : phase strobes to the array
//   adc_count      : ramp count, 0..2^ADC_BITS-1 during CONVERT, else 0
//   row_sel        : one-hot row enable during READ
//   row_valid      : row data settled; held until row_ready
//   row_ready      : downstream accepts the current row
//   busy           : not in IDLE
//   frame_done     : one-clock pulse after the last row is accepted
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | waiting for start
// S_ERASE   | erase strobe, ERASE_CYCLES clocks
// S_EXPOSE  | expose strobe, latched exposure clocks
// S_CONVERT | ramp adc_count over 2^ADC_BITS clocks
// S_READ    | per row: one settle clock, then valid until ready
module pixel_seq_ctrl
  import pixel_pkg::*;
#(
  parameter int ROWS         = DEF_ROWS,
  parameter int ADC_BITS     = DEF_ADC_BITS,
  parameter int ERASE_CYCLES = DEF_ERASE_CYCLES,
  parameter int EXP_W        = DEF_EXP_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                continuous,
  input  logic                abort,
  input  logic [EXP_W-1:0]    expose_cycles,
  output logic                erase,
  output logic                expose,
  output logic                convert,
  output logic                read,
  output logic [ADC_BITS-1:0] adc_count,
  output logic [ROWS-1:0]     row_sel,
  output logic                row_valid,
  input  logic                row_ready,
  output logic                busy,
  output logic                frame_done
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  // Wide enough for the exposure latch, the full ramp length and the erase time.
  localparam int CW = max_int(max_int(EXP_W, ADC_BITS + 1), $clog2(ERASE_CYCLES + 1));

  pixel_state_e   state;
  logic [EXP_W-1:0] exp_lat;
  logic [EXP_W-1:0] exp_fix;
  logic [RW-1:0]  row_idx;
  logic           last_row;
  logic           cnt_load;
  logic [CW-1:0]  cnt_val;
  logic           cnt_done;

  assign exp_fix  = (expose_cycles == '0) ? EXP_W'(1) : expose_cycles;
  assign last_row = (row_idx == RW'(ROWS - 1));

  // The counter is loaded on entry to each timed phase with that phase's length.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    if (!abort) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt_load = 1'b1;
            cnt_val  = CW'(ERASE_CYCLES);
          end
        end
        S_ERASE: begin
          if (cnt_done) begin
            cnt_load = 1'b1;
            cnt_val  = CW'(exp_lat);
          end
        end
        S_EXPOSE: begin
          if (cnt_done) begin
            cnt_load = 1'b1;
            cnt_val  = CW'(1) << ADC_BITS;
          end
        end
        S_READ: begin
          if (row_valid && row_ready && last_row && continuous) begin
            cnt_load = 1'b1;
            cnt_val  = CW'(ERASE_CYCLES);
          end
        end
        default: ;
      endcase
    end
  end

  pixel_cycle_counter #(.W(CW)) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      exp_lat    <= '0;
      row_idx    <= '0;
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      read       <= 1'b0;
      adc_count  <= '0;
      row_sel    <= '0;
      row_valid  <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (abort) begin
        state     <= S_IDLE;
        row_idx   <= '0;
        erase     <= 1'b0;
        expose    <= 1'b0;
        convert   <= 1'b0;
        read      <= 1'b0;
        adc_count <= '0;
        row_sel   <= '0;
        row_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state   <= S_ERASE;
              exp_lat <= exp_fix;
              erase   <= 1'b1;
              busy    <= 1'b1;
            end
          end
          S_ERASE: begin
            if (cnt_done) begin
              state  <= S_EXPOSE;
              erase  <= 1'b0;
              expose <= 1'b1;
            end
          end
          S_EXPOSE: begin
            if (cnt_done) begin
              state     <= S_CONVERT;
              expose    <= 1'b0;
              convert   <= 1'b1;
              adc_count <= '0;
            end
          end
          S_CONVERT: begin
            if (cnt_done) begin
              state     <= S_READ;
              convert   <= 1'b0;
              read      <= 1'b1;
              adc_count <= '0;
              row_idx   <= '0;
              row_sel   <= ROWS'(1);
              row_valid <= 1'b0;
            end else begin
              adc_count <= adc_count + 1'b1;
            end
          end
          S_READ: begin
            if (!row_valid) begin
              // settle clock is over for the selected row
              row_valid <= 1'b1;
            end else if (row_ready) begin
              row_valid <= 1'b0;
              if (last_row) begin
                read       <= 1'b0;
                row_sel    <= '0;
                row_idx    <= '0;
                frame_done <= 1'b1;
                if (continuous) begin
                  state   <= S_ERASE;
                  exp_lat <= exp_fix;
                  erase   <= 1'b1;
                end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                end
              end else begin
                row_idx <= row_idx + 1'b1;
                row_sel <= row_sel << 1;
              end
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/pixel_seq_ctrl.md
PIXEL_SEQ_CTRL -- requirements
Module: pixel_seq_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 2, number of pixel rows read out (>=1).
REQ-002 SHALL have parameter ADC_BITS, default 8, width of ADC ramp count.
REQ-003 SHALL have parameter ERASE_CYCLES, default 5, fixed erase duration in clocks (>=1).
REQ-004 SHALL have parameter EXP_W, default 16, width of exposure length input.
REQ-005 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port start  input  1  request one frame; honoured only in IDLE.
REQ-008 SHALL have port continuous  input  1  when high at frame end, next frame starts without start.
REQ-009 SHALL have port abort  input  1  synchronous abort to IDLE.
REQ-010 SHALL have port expose_cycles  input  EXP_W  exposure length, latched on accepted start.
REQ-011 SHALL have port erase / expose / convert / read  output  1 each  phase strobes to pixel array; one-hot or all zero.
REQ-012 SHALL have port adc_count  output  ADC_BITS  ramp count broadcast to pixel comparators.
REQ-013 SHALL have port row_sel  output  ROWS  one-hot row bus-enable; zero outside READ.
REQ-014 SHALL have port row_valid  output  1  selected row data on pixdata buses is stable.
REQ-015 SHALL have port row_ready  input  1  downstream accepts current row.
REQ-016 SHALL have port busy  output  1  high in any state except IDLE.
REQ-017 SHALL have port frame_done  output  1  one-cycle pulse after last row accepted.

Function
REQ-018 SHALL implement states IDLE, ERASE, EXPOSE, CONVERT, READ.
REQ-019 IDLE -> ERASE on start=1; latch expose_cycles; latched value 0 SHALL be treated as 1.
REQ-020 ERASE SHALL last exactly ERASE_CYCLES clocks with erase=1, then -> EXPOSE.
REQ-021 EXPOSE SHALL last exactly latched exposure count clocks with expose=1, then -> CONVERT.
REQ-022 CONVERT SHALL last 2^ADC_BITS clocks, convert=1, adc_count = 0,1,...,2^ADC_BITS-1 one step per clock, then -> READ.
REQ-023 adc_count SHALL be 0 in every state other than CONVERT (no wrap carried out).
REQ-024 READ SHALL visit rows 0..ROWS-1 in order; per row: first clock row_sel set, row_valid=0 (bus settle); following clocks row_valid=1 until row_ready=1.
REQ-025 Row transfer SHALL complete on clock where row_valid=1 and row_ready=1; row_sel and row_valid SHALL hold while row_ready=0 (unbounded stall).
REQ-026 read SHALL be 1 throughout READ.
REQ-027 On last-row transfer: frame_done=1 next cycle; state -> ERASE if continuous=1 at that edge, else IDLE.
REQ-028 start while busy=1 SHALL be ignored; exposure latch unchanged.
REQ-029 abort=1 in any state SHALL force IDLE next clock, all outputs zero, no frame_done; abort wins over start and over simultaneous last-row transfer.
REQ-030 In continuous mode the exposure latch SHALL be refreshed from expose_cycles at each frame restart.

Reset
REQ-031 reset=1 SHALL asynchronously force IDLE, clear counters and exposure latch, and drive erase, expose, convert, read, adc_count, row_sel, row_valid, busy, frame_done to 0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; first action after release is only an accepted start.

Structure
REQ-033 State enum typedef and default parameter constants SHALL live in shared package pixel_pkg.
REQ-034 Phase durations SHALL use one sub-module pixel_cycle_counter (loadable down-counter with done flag), instantiated once and reused across phases.

Verification
REQ-035 Defaults, expose_cycles=10, start pulse, row_ready=1 -> erase 5 clk, expose 10 clk, convert 256 clk (adc_count 0..255), row_sel 01 then 10, frame_done once, back to IDLE.
REQ-036 expose_cycles=0 -> expose high exactly 1 clk.
REQ-037 row_ready held 0 for 7 clk on row 1 -> row_sel=10 and row_valid=1 stable all 7 clk; transfer on first ready=1.
REQ-038 continuous=1 -> frame_done then erase asserted next clk with no start; second frame timing identical.
REQ-039 abort at CONVERT adc_count=100 -> next clk IDLE, adc_count=0, no frame_done; start during frame ignored.
REQ-040 reset asserted mid-EXPOSE between edges -> outputs zero immediately, IDLE after release.
